store_queue: RTL and testbench
==============================

Name: store_queue

Overview:
- Parametrised in-order store buffer that sits between the execute stage and the dcache.
- Accepts speculative stores at allocate and marks them committed as the ROB retires them, in order, up to COMMIT_WIDTH per cycle.
- Drains committed stores to the dcache with up to MAX_INFLIGHT requests outstanding.
- Provides byte-granular store-to-load forwarding across all live entries. Each requested byte comes from the youngest writer of that byte, and partial coverage is reported as a conflict.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
COMMIT_WIDTH, 2, maximum stores committed per cycle
MAX_INFLIGHT, 2, maximum dcache store requests accepted but not yet answered by data_ok; 1 to 4

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush; discards uncommitted entries
alloc_valid  in  1  enqueue a store this cycle
alloc_ready  out  1  space available (count < DEPTH)
alloc_wstrb  in  4  byte strobes
alloc_size  in  3  access size, passed through to the dcache
alloc_addr  in  32  virtual byte address
alloc_data  in  32  byte-lane-aligned store data
commit_cnt  in  clog2(COMMIT_WIDTH+1)  number of oldest uncommitted stores retiring this cycle
lookup_addr  in  32  load address
lookup_wstrb  in  4  load byte mask
lookup_hit  out  1  every requested byte was found in the queue
lookup_conflict  out  1  some requested bytes were found, but not all
lookup_data  out  32  forwarded bytes; bytes not found are 0
store_req  out  1  dcache write request
store_wstrb  out  4  request strobes
store_size  out  3  request size
store_addr  out  32  request address
store_data  out  32  request data
dcache_addr_ok  in  1  request accepted
dcache_data_ok  in  1  oldest outstanding write completed
empty  out  1  no live entries and nothing in flight (used by SYNC/CACHE ops)
count  out  clog2(DEPTH)+1  number of live entries

Behaviour:
- State. Four pointers, each clog2(DEPTH)+1 bits with a wrap bit: tail (next allocate), cmt (first uncommitted entry), req (next to send), free (oldest live entry). Invariant: free ≤ req ≤ cmt ≤ tail in ring order.
- Live entries are those in [free, tail). Count is tail − free. Full means count == DEPTH.
- Allocate. When alloc_valid && alloc_ready && !flush, write the entry at tail and advance tail. alloc_valid while full is dropped; the bench treats this as a protocol error.
- Commit. cmt advances by commit_cnt. commit_cnt greater than (tail − cmt) is a protocol error; cmt saturates at tail.
- Flush.
  - tail is set to cmt after the same-cycle commit is applied, so stores committed that cycle survive.
  - A same-cycle allocate is dropped.
  - Committed and in-flight entries are untouched.
- Drain.
  - The request register loads the entry at req when req != cmt, the register is free or being accepted, and outstanding < MAX_INFLIGHT.
  - store_req rises the cycle after eligibility, which gives one-cycle latency from commit to request.
  - The store_* fields stay stable while store_req && !dcache_addr_ok.
  - dcache_addr_ok advances req and increments outstanding.
  - dcache_data_ok decrements outstanding and advances free, releasing the entry.
  - addr_ok and data_ok in the same cycle leave outstanding unchanged.
  - data_ok with outstanding == 0 is ignored.
- Forwarding (combinational).
  - Candidates are all live entries plus the same-cycle allocate, which counts as youngest.
  - An entry matches when its addr[31:2] equals lookup_addr[31:2].
  - For each byte b set in lookup_wstrb, the source is the youngest matching entry with wstrb[b] set. Age is the index relative to free, modulo DEPTH.
  - lookup_hit = lookup_wstrb != 0 and all requested bytes have a source.
  - lookup_conflict = at least one requested byte has a source and lookup_hit is 0.
  - Entries released by data_ok in the current cycle still participate in forwarding.
- Wrap-around. Pointer arithmetic is modulo 2·DEPTH.
  - Full when the index bits are equal and the wrap bits differ.
  - Empty (zero live entries) when both are equal.
- Reset values.
  - Pointers and outstanding are 0.
  - store_req and all store_* outputs are 0.
  - lookup outputs are driven from empty state: lookup_hit 0, lookup_conflict 0, lookup_data 0.
  - alloc_ready 1, empty 1, count 0.
  - A reset mid-transaction abandons outstanding requests. The dcache is reset together with this block.
- Outputs. empty = (count == 0) && (outstanding == 0) && !store_req.

Test Plan:
- Full and wrap: with DEPTH=16, allocate 16 stores with no commits → alloc_ready=0, count=16; a 17th alloc is ignored. Commit 2 and complete 2 → count=14, alloc_ready=1. Run 40 stores through the ring → final data order in memory matches program order.
- Byte merge: store 0x11223344 at 0x100 with strb 1111, then 0xAA000000 at 0x100 with strb 1000; load 0x100 with mask 1111 → hit=1, data=0xAA223344.
- Partial overlap: store strb 0011 at 0x200; load mask 1111 at 0x200 → hit=0, conflict=1, data low half forwarded. A same-cycle alloc with strb 1100 to 0x200 → hit=1.
- Flush: allocate 5, commit 2, then assert flush while alloc_valid=1 and commit_cnt=1 → count=3 and the 3 entries drain; the flushed stores never appear on store_req.
- Backpressure: hold dcache_addr_ok=0 for 5 cycles → store fields stable. With MAX_INFLIGHT=2 and data_ok withheld → store_req=0 after 2 accepts. A single data_ok pulse → the next request issues the following cycle.
- Reset mid-drain: assert reset with 2 requests in flight → the next cycle has store_req=0, empty=1, count=0, alloc_ready=1.

Source files
------------

// File: rtl/store_queue.sv
// In-order store buffer between execute and dcache: speculative allocate, ROB-driven
// commit, bounded in-flight drain to the dcache and byte-granular store-to-load forwarding.
module store_queue #(
    parameter int DEPTH        = 16,
    parameter int COMMIT_WIDTH = 2,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [3:0]                        alloc_wstrb,
    input  logic [2:0]                        alloc_size,
    input  logic [31:0]                       alloc_addr,
    input  logic [31:0]                       alloc_data,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_cnt,
    input  logic [31:0]                       lookup_addr,
    input  logic [3:0]                        lookup_wstrb,
    output logic                              lookup_hit,
    output logic                              lookup_conflict,
    output logic [31:0]                       lookup_data,
    output logic                              store_req,
    output logic [3:0]                        store_wstrb,
    output logic [2:0]                        store_size,
    output logic [31:0]                       store_addr,
    output logic [31:0]                       store_data,
    input  logic                              dcache_addr_ok,
    input  logic                              dcache_data_ok,
    output logic                              empty,
    output logic [$clog2(DEPTH):0]            count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int OW = $clog2(MAX_INFLIGHT + 1);

    logic [31:0]   ent_addr_r  [DEPTH];
    logic [31:0]   ent_data_r  [DEPTH];
    logic [3:0]    ent_wstrb_r [DEPTH];
    logic [2:0]    ent_size_r  [DEPTH];

    logic [PW-1:0] tail_r, cmt_r, req_r, free_r;
    logic [OW-1:0] outst_r;
    logic          store_req_r;
    logic [3:0]    store_wstrb_r;
    logic [2:0]    store_size_r;
    logic [31:0]   store_addr_r, store_data_r;

    logic          full_s, alloc_fire_s, accept_s, release_s, load_s;
    logic [PW-1:0] count_s, cmt_room_s, cmt_step_s, cmt_next_s;
    logic [PW-1:0] tail_next_s, req_next_s, free_next_s;
    logic [OW-1:0] outst_next_s;
    logic [IW-1:0] slot_s;
    logic [3:0]    sel_s, fwd_found_s;
    logic [31:0]   fwd_data_s;
    logic          unused_lookup_s;

    // Next-state arithmetic for the four ring pointers and the in-flight counter.
    always_comb begin
        count_s      = tail_r - free_r;
        full_s       = (tail_r[IW-1:0] == free_r[IW-1:0]) && (tail_r[IW] != free_r[IW]);
        alloc_fire_s = alloc_valid && !full_s && !flush;
        accept_s     = store_req_r && dcache_addr_ok;
        release_s    = dcache_data_ok && (outst_r != '0);
        cmt_room_s   = tail_r - cmt_r;
        if (PW'(commit_cnt) > cmt_room_s) begin
            cmt_step_s = cmt_room_s;
        end else begin
            cmt_step_s = PW'(commit_cnt);
        end
        cmt_next_s = cmt_r + cmt_step_s;
        // Flush keeps everything committed up to and including this cycle's retirements.
        if (flush) begin
            tail_next_s = cmt_next_s;
        end else if (alloc_fire_s) begin
            tail_next_s = tail_r + PW'(1'b1);
        end else begin
            tail_next_s = tail_r;
        end
        if (accept_s) begin
            req_next_s = req_r + PW'(1'b1);
        end else begin
            req_next_s = req_r;
        end
        if (release_s) begin
            free_next_s = free_r + PW'(1'b1);
        end else begin
            free_next_s = free_r;
        end
        case ({accept_s, release_s})
            2'b10:   outst_next_s = outst_r + OW'(1'b1);
            2'b01:   outst_next_s = outst_r - OW'(1'b1);
            default: outst_next_s = outst_r;
        endcase
        // The pending request counts against the in-flight budget once loaded.
        load_s = (!store_req_r || accept_s) && (req_next_s != cmt_next_s) &&
                 (outst_next_s < OW'(MAX_INFLIGHT));
    end

    // Youngest-wins byte forwarding over live entries, then the same-cycle allocate.
    always_comb begin
        fwd_data_s  = 32'h0;
        fwd_found_s = 4'h0;
        slot_s      = '0;
        sel_s       = 4'h0;
        for (int a = 0; a < DEPTH; a++) begin
            slot_s = free_r[IW-1:0] + IW'(a);
            sel_s  = ((PW'(a) < count_s) && (ent_addr_r[slot_s][31:2] == lookup_addr[31:2])) ?
                     (ent_wstrb_r[slot_s] & lookup_wstrb) : 4'h0;
            for (int b = 0; b < 4; b++) begin
                fwd_data_s[8*b +: 8] = sel_s[b] ? ent_data_r[slot_s][8*b +: 8] : fwd_data_s[8*b +: 8];
            end
            fwd_found_s = fwd_found_s | sel_s;
        end
        sel_s = (alloc_fire_s && (alloc_addr[31:2] == lookup_addr[31:2])) ?
                (alloc_wstrb & lookup_wstrb) : 4'h0;
        for (int b = 0; b < 4; b++) begin
            fwd_data_s[8*b +: 8] = sel_s[b] ? alloc_data[8*b +: 8] : fwd_data_s[8*b +: 8];
        end
        fwd_found_s = fwd_found_s | sel_s;
    end

    // Entry storage written at the tail on a successful allocate.
    always_ff @(posedge clk) begin
        if (alloc_fire_s) begin
            ent_addr_r[tail_r[IW-1:0]]  <= alloc_addr;
            ent_data_r[tail_r[IW-1:0]]  <= alloc_data;
            ent_wstrb_r[tail_r[IW-1:0]] <= alloc_wstrb;
            ent_size_r[tail_r[IW-1:0]]  <= alloc_size;
        end
    end

    // Pointer and in-flight counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_r  <= '0;
            cmt_r   <= '0;
            req_r   <= '0;
            free_r  <= '0;
            outst_r <= '0;
        end else begin
            tail_r  <= tail_next_s;
            cmt_r   <= cmt_next_s;
            req_r   <= req_next_s;
            free_r  <= free_next_s;
            outst_r <= outst_next_s;
        end
    end

    // Request register: load the next committed entry, hold while unaccepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_req_r   <= 1'b0;
            store_wstrb_r <= 4'h0;
            store_size_r  <= 3'h0;
            store_addr_r  <= 32'h0;
            store_data_r  <= 32'h0;
        end else if (load_s) begin
            store_req_r   <= 1'b1;
            store_wstrb_r <= ent_wstrb_r[req_next_s[IW-1:0]];
            store_size_r  <= ent_size_r[req_next_s[IW-1:0]];
            store_addr_r  <= ent_addr_r[req_next_s[IW-1:0]];
            store_data_r  <= ent_data_r[req_next_s[IW-1:0]];
        end else if (accept_s) begin
            store_req_r   <= 1'b0;
        end else begin
            store_req_r   <= store_req_r;
        end
    end

    assign unused_lookup_s = ^lookup_addr[1:0];
    assign alloc_ready     = !full_s;
    assign count           = count_s;
    assign empty           = (count_s == '0) && (outst_r == '0) && !store_req_r;
    assign lookup_data     = fwd_data_s;
    assign lookup_hit      = (lookup_wstrb != 4'h0) && (fwd_found_s == lookup_wstrb);
    assign lookup_conflict = (fwd_found_s != 4'h0) && !lookup_hit;
    assign store_req       = store_req_r;
    assign store_wstrb     = store_wstrb_r;
    assign store_size      = store_size_r;
    assign store_addr      = store_addr_r;
    assign store_data      = store_data_r;
endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios plus a random phase, all
// checked against a queue-based reference model of the store buffer and a dcache image.
module tb_store_queue;
    localparam int DEPTH = 16;
    localparam int MAXI  = 2;

    logic        clk, reset, flush, alloc_valid, alloc_ready;
    logic [3:0]  alloc_wstrb, lookup_wstrb, store_wstrb;
    logic [2:0]  alloc_size, store_size;
    logic [31:0] alloc_addr, alloc_data, lookup_addr, lookup_data, store_addr, store_data;
    logic [1:0]  commit_cnt;
    logic        lookup_hit, lookup_conflict, store_req, dcache_addr_ok, dcache_data_ok, empty;
    logic [4:0]  count;

    store_queue #(.DEPTH(DEPTH), .COMMIT_WIDTH(2), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset), .flush(flush), .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready), .alloc_wstrb(alloc_wstrb), .alloc_size(alloc_size),
        .alloc_addr(alloc_addr), .alloc_data(alloc_data), .commit_cnt(commit_cnt),
        .lookup_addr(lookup_addr), .lookup_wstrb(lookup_wstrb), .lookup_hit(lookup_hit),
        .lookup_conflict(lookup_conflict), .lookup_data(lookup_data), .store_req(store_req),
        .store_wstrb(store_wstrb), .store_size(store_size), .store_addr(store_addr),
        .store_data(store_data), .dcache_addr_ok(dcache_addr_ok),
        .dcache_data_ok(dcache_data_ok), .empty(empty), .count(count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } ent_t;

    ent_t       q[$];
    ent_t       m_e;
    int         m_cmt, m_sent, m_outst, accepts, dc_mode;
    bit         m_req;
    logic [7:0] exp_mem[int unsigned];
    logic [7:0] dc_mem[int unsigned];
    int         total = 0;
    int         bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dc(input int mode);
        dc_mode = mode;
        if (mode == 0) begin
            dcache_addr_ok = 1'b0;
            dcache_data_ok = 1'b0;
        end
    endtask

    task automatic set_alloc(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        alloc_valid = v;
        alloc_addr  = a;
        alloc_data  = d;
        alloc_wstrb = s;
        alloc_size  = 3'd2;
    endtask

    function automatic bit alloc_fires();
        return alloc_valid && (q.size() < DEPTH) && !flush;
    endfunction

    // Reference forwarding: scan oldest to youngest, later writers overwrite bytes.
    task automatic look(input logic [31:0] a, input logic [3:0] m);
        ent_t c[$];
        logic [31:0] d;
        logic [3:0]  f;
        bit hit;
        lookup_addr  = a;
        lookup_wstrb = m;
        #1;
        c = q;
        if (alloc_fires()) c.push_back('{alloc_addr, alloc_data, alloc_wstrb, alloc_size});
        d = 32'h0;
        f = 4'h0;
        foreach (c[i]) begin
            if (c[i].addr[31:2] == a[31:2]) begin
                for (int b = 0; b < 4; b++) begin
                    if (m[b] && c[i].strb[b]) begin
                        f[b] = 1'b1;
                        d[8*b +: 8] = c[i].data[8*b +: 8];
                    end
                end
            end
        end
        hit = (m != 4'h0) && (f == m);
        chk("lookup_hit", lookup_hit, hit);
        chk("lookup_conflict", lookup_conflict, (f != 4'h0) && !hit);
        chk("lookup_data", lookup_data, d);
    endtask

    // One clock: advance the reference model with this cycle's inputs, then compare.
    task automatic tick();
        int  room, step, ncmt_n, nsent_n, outst_n;
        bit  acc, rel, load, fire;
        int unsigned k;
        if (dc_mode == 1) begin
            dcache_addr_ok = 1'b1;
            dcache_data_ok = (m_outst > 0);
        end else if (dc_mode == 2) begin
            dcache_addr_ok = ($urandom_range(0, 1) != 0);
            dcache_data_ok = ($urandom_range(0, 2) != 0);
        end
        #1;
        if (reset) begin
            q.delete();
            m_cmt = 0; m_sent = 0; m_outst = 0; m_req = 1'b0; m_e = '0;
            exp_mem.delete();
            dc_mem.delete();
        end else begin
            fire   = alloc_fires();
            room   = q.size() - m_cmt;
            step   = (int'(commit_cnt) > room) ? room : int'(commit_cnt);
            ncmt_n = m_cmt + step;
            for (int i = m_cmt; i < ncmt_n; i++) begin
                for (int b = 0; b < 4; b++) begin
                    k = {q[i].addr[31:2], 2'(b)};
                    if (q[i].strb[b]) exp_mem[k] = q[i].data[8*b +: 8];
                end
            end
            if (store_req && dcache_addr_ok) begin
                accepts++;
                for (int b = 0; b < 4; b++) begin
                    k = {store_addr[31:2], 2'(b)};
                    if (store_wstrb[b]) dc_mem[k] = store_data[8*b +: 8];
                end
            end
            acc     = m_req && dcache_addr_ok;
            rel     = dcache_data_ok && (m_outst > 0);
            nsent_n = m_sent + int'(acc);
            outst_n = m_outst + int'(acc) - int'(rel);
            load    = (!m_req || acc) && (nsent_n < ncmt_n) && (outst_n < MAXI);
            if (load) begin
                m_req = 1'b1;
                m_e   = q[nsent_n];
            end else if (acc) begin
                m_req = 1'b0;
            end
            if (flush) begin
                while (q.size() > ncmt_n) void'(q.pop_back());
            end else if (fire) begin
                q.push_back('{alloc_addr, alloc_data, alloc_wstrb, alloc_size});
            end
            if (rel) begin
                void'(q.pop_front());
                ncmt_n--;
                nsent_n--;
            end
            m_cmt = ncmt_n; m_sent = nsent_n; m_outst = outst_n;
        end
        @(posedge clk);
        #1;
        chk("store_req", store_req, m_req);
        chk("store_addr", store_addr, m_e.addr);
        chk("store_data", store_data, m_e.data);
        chk("store_wstrb", store_wstrb, m_e.strb);
        chk("store_size", store_size, m_e.size);
        chk("count", count, q.size());
        chk("alloc_ready", alloc_ready, q.size() < DEPTH);
        chk("empty", empty, (q.size() == 0) && (m_outst == 0) && !m_req);
    endtask

    task automatic idle();
        set_alloc(1'b0, 32'h0, 32'h0, 4'h0);
        commit_cnt = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic commit_all();
        for (int i = 0; i < 40 && m_cmt < q.size(); i++) begin
            commit_cnt = 2'((q.size() - m_cmt) < 2 ? (q.size() - m_cmt) : 2);
            tick();
        end
        commit_cnt = 2'd0;
    endtask

    task automatic drain();
        dc(1);
        for (int i = 0; i < 300 && !(q.size() == 0 && !m_req && m_outst == 0); i++) tick();
        chk("drain_empty", empty, 1'b1);
        dc(0);
    endtask

    task automatic mem_chk(input string tag);
        logic [7:0] o;
        foreach (exp_mem[k]) begin
            o = dc_mem.exists(k) ? dc_mem[k] : 8'hxx;
            chk(tag, o, exp_mem[k]);
        end
    endtask

    initial begin
        logic [31:0] sa, sd;
        int n, unc;
        reset = 1'b1; dc(0); idle();
        lookup_addr = 32'h0; lookup_wstrb = 4'h0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_count", count, 5'd0);
        chk("rst_ready", alloc_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_req", store_req, 1'b0);
        look(32'h100, 4'hF);
        chk("rst_lookup_data", lookup_data, 32'h0);

        // Fill to capacity, then overflow attempt.
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'hF);
            tick();
        end
        chk("full_count", count, 5'd16);
        chk("full_ready", alloc_ready, 1'b0);
        set_alloc(1'b1, 32'h1100, 32'hDEADBEEF, 4'hF);
        tick();
        chk("overflow_count", count, 5'd16);
        idle();
        commit_cnt = 2'd2;
        tick();
        chk("commit_latency", store_req, 1'b1);
        commit_cnt = 2'd0;
        dc(1);
        repeat (6) tick();
        chk("after2_count", count, 5'd14);
        chk("after2_ready", alloc_ready, 1'b1);

        // Ring traffic with repeated addresses so memory order matters.
        n = 0;
        for (int i = 0; i < 400 && n < 40; i++) begin
            unc = q.size() - m_cmt;
            commit_cnt = 2'($urandom_range(0, unc < 2 ? unc : 2));
            if (q.size() < DEPTH) begin
                set_alloc(1'b1, 32'h2000 + 32'(4 * (n % 8)), $urandom, 4'($urandom_range(1, 15)));
                n++;
            end else begin
                set_alloc(1'b0, 32'h0, 32'h0, 4'h0);
            end
            tick();
        end
        idle();
        commit_all();
        drain();
        mem_chk("ring_mem");

        // Byte merge from two writers.
        set_alloc(1'b1, 32'h100, 32'h11223344, 4'b1111); tick();
        set_alloc(1'b1, 32'h100, 32'hAA000000, 4'b1000); tick();
        idle();
        look(32'h100, 4'hF);
        chk("merge_hit", lookup_hit, 1'b1);
        chk("merge_data", lookup_data, 32'hAA223344);
        commit_all();
        drain();

        // Partial overlap, completed by a same-cycle allocate.
        set_alloc(1'b1, 32'h200, 32'h00005566, 4'b0011); tick();
        idle();
        look(32'h200, 4'hF);
        chk("partial_conflict", lookup_conflict, 1'b1);
        chk("partial_data", lookup_data, 32'h00005566);
        set_alloc(1'b1, 32'h200, 32'h77880000, 4'b1100);
        look(32'h200, 4'hF);
        chk("sameyc_hit", lookup_hit, 1'b1);
        chk("samecyc_data", lookup_data, 32'h77885566);
        tick();
        idle();
        commit_all();
        drain();

        // Flush with same-cycle commit and allocate.
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 32'h400 + 32'(4 * i), 32'hF0 + 32'(i), 4'hF);
            tick();
        end
        idle();
        commit_cnt = 2'd2; tick();
        set_alloc(1'b1, 32'h500, 32'h12345678, 4'hF);
        commit_cnt = 2'd1; flush = 1'b1;
        tick();
        idle();
        chk("flush_count", count, 5'd3);
        accepts = 0;
        drain();
        chk("flush_accepts", accepts, 3);
        chk("flushed_40c", dc_mem.exists(32'h40C), 1'b0);
        chk("flushed_410", dc_mem.exists(32'h410), 1'b0);
        chk("flushed_500", dc_mem.exists(32'h500), 1'b0);

        // Backpressure and in-flight limit.
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, 32'h600 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
            tick();
        end
        idle();
        commit_cnt = 2'd2; tick();
        commit_cnt = 2'd2; tick();
        commit_cnt = 2'd0;
        sa = store_addr; sd = store_data;
        chk("bp_req", store_req, 1'b1);
        repeat (5) begin
            tick();
            chk("bp_addr_stable", store_addr, sa);
            chk("bp_data_stable", store_data, sd);
        end
        dcache_addr_ok = 1'b1;
        tick(); tick();
        chk("inflight_cap", store_req, 1'b0);
        tick(); tick();
        chk("inflight_cap_hold", store_req, 1'b0);
        dcache_data_ok = 1'b1; tick();
        dcache_data_ok = 1'b0;
        chk("dataok_reissue", store_req, 1'b1);
        tick();

        // Reset with two requests in flight.
        dcache_addr_ok = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("midrst_req", store_req, 1'b0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_count", count, 5'd0);
        chk("midrst_ready", alloc_ready, 1'b1);

        // Random traffic against the model.
        dc(2);
        for (int i = 0; i < 600; i++) begin
            unc = q.size() - m_cmt;
            commit_cnt = 2'($urandom_range(0, unc < 2 ? unc : 2));
            flush = ($urandom_range(0, 19) == 0);
            set_alloc((q.size() < DEPTH) && ($urandom_range(0, 2) != 0),
                      32'h300 + 32'(4 * $urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            alloc_size = 3'($urandom_range(0, 7));
            look(32'h300 + 32'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            tick();
        end
        idle();
        commit_all();
        drain();
        mem_chk("rand_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
